prv_trap_ctrl: RTL

Machine-mode trap controller in the privilege block, downstream of the hazard unit's exception/return reporting. It takes synchronous exception flags, `mret`, `epc`/`badaddr` and `pipe_clear`, plus the level interrupt lines. It prioritises them and waits for the pipeline to drain. It then produces the `intr` / `insert_pc` / `priv_pc` redirect back to the hazard unit, together with one-cycle CSR update strobes (`mcause`, `mepc`, `mtval`, `mstatus`) for the CSR file. No delegation: all traps go to M-mode.

---
 rtl/prv_trap_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prv_trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions, interrupts and mret,
// holds the flush request until the pipeline drains, then issues the redirect.
module prv_trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        mal_insn,
  input  logic        fault_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic        fault_insn_page,
  input  logic        fault_load_page,
  input  logic        fault_store_page,
  input  logic        prot_fault_i,
  input  logic        prot_fault_l,
  input  logic        prot_fault_s,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic [31:0] mie_bits,
  input  logic        mstatus_mie,
  input  logic [1:0]  curr_privilege_level,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        trap_we,
  output logic        ret_we,
  output logic [31:0] cause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] TRAP_PEND = 2'd1;
  localparam logic [1:0] RET_PEND  = 2'd2;
  localparam logic [1:0] REDIRECT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        is_ret_q, is_ret_d;
  logic        is_int_q, is_int_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] priv_pc_q, priv_pc_d;

  logic        exc_any;
  logic [4:0]  exc_code;
  logic        int_glb;
  logic [2:0]  int_pend;
  logic [4:0]  int_code;
  logic [31:0] trap_target;
  logic        unused_mie;

  assign unused_mie = ^{mie_bits[31:12], mie_bits[10:8], mie_bits[6:4], mie_bits[2:0]};

  always_comb begin
    exc_any  = 1'b1;
    exc_code = 5'd0;
    if (fault_insn_page)               exc_code = 5'd12;
    else if (fault_insn | prot_fault_i) exc_code = 5'd1;
    else if (illegal_insn)             exc_code = 5'd2;
    else if (mal_insn)                 exc_code = 5'd0;
    else if (breakpoint)               exc_code = 5'd3;
    else if (env)                      exc_code = 5'd8 + {3'd0, curr_privilege_level};
    else if (mal_l)                    exc_code = 5'd4;
    else if (mal_s)                    exc_code = 5'd6;
    else if (fault_load_page)          exc_code = 5'd13;
    else if (fault_store_page)         exc_code = 5'd15;
    else if (fault_l | prot_fault_l)   exc_code = 5'd5;
    else if (fault_s | prot_fault_s)   exc_code = 5'd7;
    else                               exc_any  = 1'b0;
  end

  // Below M-mode interrupts are always globally enabled.
  assign int_glb  = mstatus_mie | (curr_privilege_level != 2'b11);
  assign int_pend = {ext_int & mie_bits[11], soft_int & mie_bits[3], timer_int & mie_bits[7]}
                    & {3{int_glb}};

  always_comb begin
    int_code = 5'd7;
    if (int_pend[2])      int_code = 5'd11;
    else if (int_pend[1]) int_code = 5'd3;
  end

  assign trap_target = {mtvec[31:2], 2'b00}
                     + (((mtvec[1:0] == 2'b01) && is_int_q) ? {25'd0, code_q, 2'b00} : 32'd0);

  // Handshake: intr is a request held high until pipe_clear is seen high on a
  // clock edge in a pend state; pipe_clear in any other state is ignored.
  always_comb begin
    state_d   = state_q;
    is_ret_d  = is_ret_q;
    is_int_d  = is_int_q;
    code_d    = code_q;
    mepc_d    = mepc_q;
    mtval_d   = mtval_q;
    priv_pc_d = priv_pc_q;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d  = TRAP_PEND;
          is_ret_d = 1'b0;
          is_int_d = 1'b0;
          code_d   = exc_code;
          mepc_d   = epc;
          mtval_d  = badaddr;
        end else if (|int_pend) begin
          state_d  = TRAP_PEND;
          is_ret_d = 1'b0;
          is_int_d = 1'b1;
          code_d   = int_code;
          mepc_d   = epc;
          mtval_d  = 32'd0;
        end else if (mret) begin
          state_d  = RET_PEND;
          is_ret_d = 1'b1;
        end
      end
      TRAP_PEND, RET_PEND: begin
        if (pipe_clear) begin
          state_d   = REDIRECT;
          priv_pc_d = is_ret_q ? mepc : trap_target;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      is_ret_q  <= 1'b0;
      is_int_q  <= 1'b0;
      code_q    <= 5'd0;
      mepc_q    <= 32'd0;
      mtval_q   <= 32'd0;
      priv_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      is_ret_q  <= is_ret_d;
      is_int_q  <= is_int_d;
      code_q    <= code_d;
      mepc_q    <= mepc_d;
      mtval_q   <= mtval_d;
      priv_pc_q <= priv_pc_d;
    end
  end

  assign intr      = (state_q != IDLE);
  assign insert_pc = (state_q == REDIRECT);
  assign trap_we   = insert_pc & ~is_ret_q;
  assign ret_we    = insert_pc & is_ret_q;
  assign priv_pc   = priv_pc_q;
  assign cause_o   = {is_int_q, 26'd0, code_q};
  assign mepc_o    = mepc_q;
  assign mtval_o   = mtval_q;
  assign state_o   = state_q;

endmodule
